// File: rtl/packet_inject.sv
// Node-side packetizer for a router's inject port: turns (dst, len) requests plus a payload
// stream into HEAD/BODY/TAIL/SINGLE flits under credit flow control.
module packet_inject #(
  parameter int unsigned CUR_X      = 0,
  parameter int unsigned CUR_Y      = 0,
  parameter int unsigned CUR_Z      = 0,
  parameter int unsigned CMP_MODE   = 0,
  parameter int unsigned BUF_DEPTH  = 4,
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned FLIT_SIZE  = 32,
  parameter int unsigned HEADER_LEN = 2,
  parameter int unsigned XW         = 2,
  parameter int unsigned YW         = 2,
  parameter int unsigned ZW         = 2,
  parameter int unsigned XSIZE      = 4,
  parameter int unsigned YSIZE      = 4,
  parameter int unsigned ZSIZE      = 4,
  parameter int unsigned CMP_W      = 5,
  localparam int unsigned LW        = $clog2(MAX_LEN + 1),
  localparam int unsigned PW        = FLIT_SIZE - HEADER_LEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [XW-1:0]        i_req_dst_x,
  input  logic [YW-1:0]        i_req_dst_y,
  input  logic [ZW-1:0]        i_req_dst_z,
  input  logic [LW-1:0]        i_req_len,
  input  logic                 i_pay_valid,
  output logic                 o_pay_ready,
  input  logic [PW-1:0]        i_pay_data,
  input  logic                 i_credit_in,
  output logic [FLIT_SIZE-1:0] o_flit_out,
  output logic                 o_flit_valid_out,
  output logic                 o_busy,
  output logic                 o_credit_err
);

  localparam int unsigned CW  = $clog2(BUF_DEPTH + 1);
  localparam int unsigned HPW = FLIT_SIZE - HEADER_LEN - 1 - XW - YW - ZW - CMP_W;

  localparam logic [HEADER_LEN-1:0] T_HEAD   = HEADER_LEN'(0);
  localparam logic [HEADER_LEN-1:0] T_BODY   = HEADER_LEN'(1);
  localparam logic [HEADER_LEN-1:0] T_TAIL   = HEADER_LEN'(2);
  localparam logic [HEADER_LEN-1:0] T_SINGLE = HEADER_LEN'(3);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_credits;
  logic                 r_credit_err;
  logic [CMP_W-1:0]     r_ts;
  logic [XW-1:0]        r_dx;
  logic [YW-1:0]        r_dy;
  logic [ZW-1:0]        r_dz;
  logic [LW-1:0]        r_len;
  logic [LW-1:0]        r_cnt;
  logic [CMP_W-1:0]     r_cmp;
  logic [FLIT_SIZE-1:0] r_flit;
  logic                 r_flit_valid;

  logic                  w_send;
  logic                  w_len_ok;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_credit_ok;
  logic [CMP_W-1:0]      w_dist;
  logic [CMP_W-1:0]      w_cmp;
  logic [HEADER_LEN-1:0] w_type;
  logic [FLIT_SIZE-1:0]  w_flit;

  // Minimal hop count along one torus ring.
  function automatic logic [CMP_W-1:0] f_ring_dist(input int unsigned cur, input int unsigned dst,
                                                   input int unsigned size);
    int unsigned d;
    d = (cur > dst) ? (cur - dst) : (dst - cur);
    return (d <= size - d) ? CMP_W'(d) : CMP_W'(size - d);
  endfunction

  assign w_dist = f_ring_dist(CUR_X, 32'(i_req_dst_x), XSIZE)
                + f_ring_dist(CUR_Y, 32'(i_req_dst_y), YSIZE)
                + f_ring_dist(CUR_Z, 32'(i_req_dst_z), ZSIZE);
  assign w_cmp  = (CMP_MODE == 1) ? r_ts : w_dist;

  assign w_send      = (r_state == S_SEND) && i_pay_valid && (r_credits != '0);
  assign w_len_ok    = (i_req_len != '0) && (i_req_len <= LW'(MAX_LEN));
  assign w_accept    = (r_state == S_IDLE) && i_req_valid && w_len_ok;
  assign w_last      = (r_cnt == r_len - LW'(1));
  assign w_credit_ok = i_credit_in && (r_credits != CW'(BUF_DEPTH));

  // Flit type from position within the packet.
  always_comb begin
    w_type = T_BODY;
    if (r_len == LW'(1))      w_type = T_SINGLE;
    else if (r_cnt == '0)     w_type = T_HEAD;
    else if (w_last)          w_type = T_TAIL;
  end

  always_comb begin
    w_flit = {w_type, i_pay_data};
    if (w_type == T_HEAD || w_type == T_SINGLE)
      w_flit = {w_type, 1'b0, r_dx, r_dy, r_dz, r_cmp, i_pay_data[HPW-1:0]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_credits    <= CW'(BUF_DEPTH);
      r_credit_err <= 1'b0;
      r_ts         <= '0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_dz         <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_cmp        <= '0;
      r_flit       <= '0;
      r_flit_valid <= 1'b0;
    end else begin
      r_ts         <= r_ts + CMP_W'(1);
      r_flit_valid <= w_send;
      if (w_send) r_flit <= w_flit;

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dx    <= i_req_dst_x;
            r_dy    <= i_req_dst_y;
            r_dz    <= i_req_dst_z;
            r_len   <= i_req_len;
            r_cmp   <= w_cmp;
            r_cnt   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_send) begin
            r_cnt <= r_cnt + LW'(1);
            if (w_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A credit arriving with the buffer already fully credited is dropped and flagged.
      if (i_credit_in && !w_credit_ok) r_credit_err <= 1'b1;
      if (w_send && !w_credit_ok)      r_credits <= r_credits - CW'(1);
      else if (!w_send && w_credit_ok) r_credits <= r_credits + CW'(1);
    end
  end

  assign o_req_ready      = (r_state == S_IDLE);
  assign o_busy           = (r_state != S_IDLE);
  assign o_pay_ready      = w_send;
  assign o_flit_out       = r_flit;
  assign o_flit_valid_out = r_flit_valid;
  assign o_credit_err     = r_credit_err;

endmodule

// File: tb/tb_packet_inject.sv
// Randomized bench for packet_inject: three differently configured instances, each tracked by
// a transaction-level model, plus directed scenarios for the key corner cases.
module tb_packet_inject;

  localparam int unsigned N = 3;

  logic        clk;
  logic        rst;
  logic        req_valid [N];
  logic [1:0]  dst_x [N];
  logic [1:0]  dst_y [N];
  logic [1:0]  dst_z [N];
  logic [3:0]  req_len [N];
  logic        pay_valid [N];
  logic [29:0] pay [N];
  logic        credit_in [N];
  logic        req_ready [N];
  logic        pay_ready [N];
  logic [31:0] flit [N];
  logic        fv [N];
  logic        busy [N];
  logic        cerr [N];

  int cfg_buf  [N] = '{4, 2, 3};
  int cfg_mode [N] = '{0, 1, 0};
  int cfg_x    [N] = '{0, 1, 3};
  int cfg_y    [N] = '{0, 2, 1};
  int cfg_z    [N] = '{0, 3, 2};

  bit          m_busy [N];
  bit          m_err [N];
  bit          m_fv [N];
  int          m_dx [N], m_dy [N], m_dz [N], m_len [N], m_cnt [N], m_cmp [N], m_cred [N], m_ts [N];
  logic [31:0] m_flit [N];

  int n_total = 0;
  int n_bad   = 0;

  packet_inject #(.CUR_X(0), .CUR_Y(0), .CUR_Z(0), .CMP_MODE(0), .BUF_DEPTH(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_dst_x(dst_x[0]), .i_req_dst_y(dst_y[0]), .i_req_dst_z(dst_z[0]), .i_req_len(req_len[0]),
    .i_pay_valid(pay_valid[0]), .o_pay_ready(pay_ready[0]), .i_pay_data(pay[0]),
    .i_credit_in(credit_in[0]), .o_flit_out(flit[0]), .o_flit_valid_out(fv[0]),
    .o_busy(busy[0]), .o_credit_err(cerr[0]));

  packet_inject #(.CUR_X(1), .CUR_Y(2), .CUR_Z(3), .CMP_MODE(1), .BUF_DEPTH(2)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_dst_x(dst_x[1]), .i_req_dst_y(dst_y[1]), .i_req_dst_z(dst_z[1]), .i_req_len(req_len[1]),
    .i_pay_valid(pay_valid[1]), .o_pay_ready(pay_ready[1]), .i_pay_data(pay[1]),
    .i_credit_in(credit_in[1]), .o_flit_out(flit[1]), .o_flit_valid_out(fv[1]),
    .o_busy(busy[1]), .o_credit_err(cerr[1]));

  packet_inject #(.CUR_X(3), .CUR_Y(1), .CUR_Z(2), .CMP_MODE(0), .BUF_DEPTH(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid[2]), .o_req_ready(req_ready[2]),
    .i_req_dst_x(dst_x[2]), .i_req_dst_y(dst_y[2]), .i_req_dst_z(dst_z[2]), .i_req_len(req_len[2]),
    .i_pay_valid(pay_valid[2]), .o_pay_ready(pay_ready[2]), .i_pay_data(pay[2]),
    .i_credit_in(credit_in[2]), .o_flit_out(flit[2]), .o_flit_valid_out(fv[2]),
    .o_busy(busy[2]), .o_credit_err(cerr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hop distance on a 4-node ring.
  function automatic int ring_dist(input int a, input int b);
    int d;
    d = (a > b) ? a - b : b - a;
    return (d < 4 - d) ? d : 4 - d;
  endfunction

  // Advance the model of instance i across one clock edge, using the inputs now applied.
  task automatic model_step(input int i);
    bit send;
    int old, ty;
    if (rst) begin
      m_busy[i] = 0; m_err[i] = 0; m_fv[i] = 0; m_flit[i] = '0;
      m_cred[i] = cfg_buf[i]; m_ts[i] = 0; m_cnt[i] = 0;
      return;
    end
    send = m_busy[i] && pay_valid[i] && (m_cred[i] > 0);
    old  = m_cred[i];
    if (credit_in[i] && old == cfg_buf[i]) m_err[i] = 1;
    m_cred[i] = old - (send ? 1 : 0) + ((credit_in[i] && old != cfg_buf[i]) ? 1 : 0);
    m_fv[i] = send;
    if (send) begin
      if (m_len[i] == 1)               ty = 3;
      else if (m_cnt[i] == 0)          ty = 0;
      else if (m_cnt[i] == m_len[i]-1) ty = 2;
      else                             ty = 1;
      if (ty == 0 || ty == 3)
        m_flit[i] = (32'(ty) << 30) | (32'(m_dx[i]) << 27) | (32'(m_dy[i]) << 25)
                  | (32'(m_dz[i]) << 23) | (32'(m_cmp[i] % 32) << 18) | (32'(pay[i]) % 32'h40000);
      else
        m_flit[i] = (32'(ty) << 30) | 32'(pay[i]);
      m_cnt[i]++;
      if (m_cnt[i] == m_len[i]) m_busy[i] = 0;
    end else if (!m_busy[i] && req_valid[i] && req_len[i] >= 1 && req_len[i] <= 8) begin
      m_busy[i] = 1;
      m_dx[i] = int'(dst_x[i]); m_dy[i] = int'(dst_y[i]); m_dz[i] = int'(dst_z[i]);
      m_len[i] = int'(req_len[i]);
      m_cnt[i] = 0;
      if (cfg_mode[i] == 1) m_cmp[i] = m_ts[i];
      else m_cmp[i] = ring_dist(cfg_x[i], m_dx[i]) + ring_dist(cfg_y[i], m_dy[i])
                    + ring_dist(cfg_z[i], m_dz[i]);
    end
    m_ts[i] = (m_ts[i] + 1) % 32;
  endtask

  // One clock: check handshake outputs, advance the model, then check registered outputs.
  task automatic step();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("pay_ready%0d", i), 32'(pay_ready[i]),
            32'(m_busy[i] && pay_valid[i] && m_cred[i] > 0));
      model_step(i);
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("flit_valid%0d", i), 32'(fv[i]), 32'(m_fv[i]));
      check($sformatf("flit%0d", i), flit[i], m_flit[i]);
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(m_busy[i]));
      check($sformatf("req_ready%0d", i), 32'(req_ready[i]), 32'(!m_busy[i]));
      check($sformatf("credit_err%0d", i), 32'(cerr[i]), 32'(m_err[i]));
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 0; dst_x[i] = 0; dst_y[i] = 0; dst_z[i] = 0; req_len[i] = 0;
      pay_valid[i] = 0; pay[i] = 0; credit_in[i] = 0;
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = ($urandom % 4) == 0;
      dst_x[i]     = 2'($urandom);
      dst_y[i]     = 2'($urandom);
      dst_z[i]     = 2'($urandom);
      req_len[i]   = 4'($urandom_range(0, 9));
      pay_valid[i] = ($urandom % 4) != 0;
      pay[i]       = 30'($urandom);
      credit_in[i] = (m_cred[i] < cfg_buf[i]) && (($urandom % 3) == 0);
    end
  endtask

  // Finish open packets and return all outstanding credits.
  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = 0; pay_valid[i] = 1; pay[i] = 30'($urandom);
        credit_in[i] = m_cred[i] < cfg_buf[i];
      end
      step();
      done = 1;
      for (int i = 0; i < N; i++)
        if (m_busy[i] || m_cred[i] != cfg_buf[i]) done = 0;
    end
    if (!done) begin
      n_total++; n_bad++;
      $display("FAIL drain: packets/credits did not settle within 60 cycles");
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    step();
    step();
    check("rst_flit", flit[0], 32'h0);
    check("rst_fv", 32'(fv[0]), 32'h0);
    check("rst_req_ready", 32'(req_ready[0]), 32'h1);
    rst = 0;

    // Single-flit packet from (0,0,0) to (3,2,1): cmp = 1+2+1.
    req_valid[0] = 1; dst_x[0] = 3; dst_y[0] = 2; dst_z[0] = 1; req_len[0] = 1;
    step();
    req_valid[0] = 0; pay_valid[0] = 1; pay[0] = 30'h2ABCD;
    step();
    check("t1_fv", 32'(fv[0]), 32'h1);
    check("t1_type", 32'(flit[0][31:30]), 32'h3);
    check("t1_vc", 32'(flit[0][29]), 32'h0);
    check("t1_cmp", 32'(flit[0][22:18]), 32'h4);
    pay_valid[0] = 0;
    step();

    // Two-credit instance: stall after two flits, resume one cycle after each credit.
    req_valid[1] = 1; req_len[1] = 4; dst_x[1] = 2;
    step();
    req_valid[1] = 0; pay_valid[1] = 1; pay[1] = 30'h111;
    step();
    pay[1] = 30'h222;
    step();
    #1 check("t3_stall", 32'(pay_ready[1]), 32'h0);
    credit_in[1] = 1;
    step();
    credit_in[1] = 0;
    step();
    check("t3_third", 32'(fv[1]), 32'h1);
    check("t3_third_type", 32'(flit[1][31:30]), 32'h1);
    credit_in[1] = 1;
    step();
    credit_in[1] = 0;
    step();
    check("t3_tail_type", 32'(flit[1][31:30]), 32'h2);
    drain();

    // Credit with send keeps count; credit at full count flags an error.
    req_valid[0] = 1; req_len[0] = 3;
    step();
    req_valid[0] = 0; pay_valid[0] = 1;
    step();
    step();
    credit_in[0] = 1;
    step();
    pay_valid[0] = 0;
    step();
    step();
    check("t4_err_before", 32'(cerr[0]), 32'h0);
    step();
    check("t4_err_after", 32'(cerr[0]), 32'h1);
    credit_in[0] = 0;
    step();

    // Timestamp compare: accept at 0x1F, then again right after wrap.
    for (int k = 0; k < 40 && m_ts[1] != 31; k++) step();
    if (m_ts[1] != 31) begin
      n_total++; n_bad++;
      $display("FAIL t5_sync: timestamp 0x1F not reached");
    end
    req_valid[1] = 1; req_len[1] = 1;
    step();
    req_valid[1] = 0; pay_valid[1] = 1;
    step();
    check("t5_cmp", 32'(flit[1][22:18]), 32'h1F);
    pay_valid[1] = 0; req_valid[1] = 1;
    step();
    req_valid[1] = 0; pay_valid[1] = 1;
    step();
    check("t5_wrap_cmp", 32'(flit[1][22:18]), 32'h1);
    clear_inputs();
    drain();

    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      step();
    end
    drain();

    // Reset in the middle of a six-flit packet.
    req_valid[0] = 1; req_len[0] = 6; dst_y[0] = 3;
    step();
    req_valid[0] = 0; pay_valid[0] = 1;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    check("t6_req_ready", 32'(req_ready[0]), 32'h1);
    check("t6_busy", 32'(busy[0]), 32'h0);
    check("t6_fv", 32'(fv[0]), 32'h0);
    check("t6_err_clear", 32'(cerr[0]), 32'h0);
    step();
    check("t6_no_flit", 32'(fv[0]), 32'h0);
    pay_valid[0] = 0; credit_in[0] = 1;
    step();
    check("t6_full_credits", 32'(cerr[0]), 32'h1);
    clear_inputs();
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
